// File: rtl/mult_bcd_sequencer.sv
// Signed shift-add multiplier, serial double-dabble BCD conversion and a scrollable 4-digit window.
// Optional macro MULT_SEQ_ZERO_SKIP_EN: leave MULT as soon as the multiplier runs out of set bits.
module mult_bcd_sequencer #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic                    scroll_l,
    input  logic                    scroll_r,
    output logic                    busy,
    output logic                    done,
    output logic                    sign,
    output logic [4*DIGITS-1:0]     bcd,
    output logic [15:0]             window
);

    localparam int PW      = 2 * WIDTH;
    localparam int BW      = 4 * DIGITS;
    localparam int CNT_W   = $clog2(PW);
    localparam int OFF_MAX = DIGITS - 4;
    localparam int OFF_W   = (OFF_MAX > 0) ? $clog2(OFF_MAX + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        CONV,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic [PW-1:0]      mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [PW-1:0]      prod_q, prod_d;
    logic [BW-1:0]      work_q, work_d;
    logic [BW-1:0]      bcd_q, bcd_d;
    logic               sign_q, sign_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OFF_W-1:0]   offset_q, offset_d;

    // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1) as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        logic [WIDTH-1:0] u;
        u = v;
        return v[WIDTH-1] ? (~u + 1'b1) : u;
    endfunction

    function automatic logic [BW-1:0] dabble_step(input logic [BW-1:0] w, input logic bit_in);
        logic [BW-1:0] adj;
        adj = w;
        for (int i = 0; i < DIGITS; i++) begin
            if (adj[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        return {adj[BW-2:0], bit_in};
    endfunction

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        work_d   = work_q;
        bcd_d    = bcd_q;
        sign_d   = sign_q;
        cnt_d    = cnt_q;
        offset_d = offset_q;

        if (scroll_l && !scroll_r) begin
            if (offset_q < OFF_W'(OFF_MAX))
                offset_d = offset_q + 1'b1;
        end else if (scroll_r && !scroll_l) begin
            if (offset_q != '0)
                offset_d = offset_q - 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = MULT;
                    mcand_d  = {{WIDTH{1'b0}}, magnitude(a)};
                    mplier_d = magnitude(b);
                    prod_d   = '0;
                    work_d   = '0;
                    cnt_d    = '0;
                    offset_d = '0;
                    sign_d   = (a[WIDTH-1] ^ b[WIDTH-1]) && (a != '0) && (b != '0);
                end
            end
            MULT: begin
`ifdef MULT_SEQ_ZERO_SKIP_EN
                if (mplier_q == '0) begin
                    state_d = CONV;
                    cnt_d   = '0;
                end else begin
                    if (mplier_q[0])
                        prod_d = prod_q + mcand_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end
`else
                if (cnt_q == CNT_W'(WIDTH)) begin
                    state_d = CONV;
                    cnt_d   = '0;
                end else begin
                    if (mplier_q[0])
                        prod_d = prod_q + mcand_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                end
`endif
            end
            CONV: begin
                work_d = dabble_step(work_q, prod_q[PW-1]);
                prod_d = prod_q << 1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(PW - 1)) begin
                    bcd_d   = work_d;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!start)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            work_q   <= '0;
            bcd_q    <= '0;
            sign_q   <= 1'b0;
            cnt_q    <= '0;
            offset_q <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            work_q   <= work_d;
            bcd_q    <= bcd_d;
            sign_q   <= sign_d;
            cnt_q    <= cnt_d;
            offset_q <= offset_d;
        end
    end

    assign busy   = (state_q == MULT) || (state_q == CONV);
    assign done   = (state_q == DONE);
    assign sign   = sign_q;
    assign bcd    = bcd_q;
    assign window = 16'(bcd_q >> {offset_q, 2'b00});

endmodule

// File: tb/tb_mult_bcd_sequencer.sv
// Scoreboard bench for mult_bcd_sequencer: expected results queued at start, compared at done.
module tb_mult_bcd_sequencer;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 5;
`ifdef MULT_SEQ_ZERO_SKIP_EN
    localparam bit ZERO_SKIP = 1'b1;
`else
    localparam bit ZERO_SKIP = 1'b0;
`endif
    localparam int LAT_3X5 = ZERO_SKIP ? 21 : 26;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic scroll_l = 1'b0;
    logic scroll_r = 1'b0;
    logic signed [WIDTH-1:0] a = '0;
    logic signed [WIDTH-1:0] b = '0;
    logic busy, done, sign;
    logic [4*DIGITS-1:0] bcd;
    logic [15:0] window;

    typedef struct {
        logic [4*DIGITS-1:0] bcd;
        logic                sign;
        int                  lat;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_pass   = 0;

    mult_bcd_sequencer #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .scroll_l(scroll_l), .scroll_r(scroll_r),
        .busy(busy), .done(done), .sign(sign), .bcd(bcd), .window(window)
    );

    always #5 clk = ~clk;

    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int exp_lat(input int bv);
        int m, idx, k_skip;
        m = (bv < 0) ? -bv : bv;
        idx = 0;
        while ((m >> (idx + 1)) != 0) idx++;
        k_skip = (m == 0) ? 1 : idx + 2;
        return 1 + 2 * WIDTH + (ZERO_SKIP ? k_skip : WIDTH + 1);
    endfunction

    // Drives one start edge and queues the expected result; returns just after that edge.
    task automatic launch(input int av, input int bv);
        exp_t e;
        int p;
        repeat (2) @(negedge clk);
        a = WIDTH'(av);
        b = WIDTH'(bv);
        start = 1'b1;
        p = av * bv;
        e.sign = (p < 0);
        e.bcd  = to_bcd((p < 0) ? -p : p);
        e.lat  = exp_lat(bv);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int lat0, output int lat, output int busy_cyc,
                             output bit both_hi, output bit timed_out);
        lat = lat0;
        busy_cyc = 0;
        both_hi = 1'b0;
        timed_out = 1'b0;
        while (!done) begin
            if (busy) busy_cyc++;
            if (lat >= 300) begin
                timed_out = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        both_hi = done && busy;
    endtask

    task automatic pulse_scroll(input logic l, input logic r);
        @(negedge clk);
        scroll_l = l;
        scroll_r = r;
        @(posedge clk);
        #1;
        scroll_l = 1'b0;
        scroll_r = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_checks++;
        if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
        n_checks++;
        if (sign !== 1'b0) $display("FAIL reset_sign: got %b expected 0", sign); else n_pass++;
        n_checks++;
        if (bcd !== '0) $display("FAIL reset_bcd: got %h expected 0", bcd); else n_pass++;
        n_checks++;
        if (window !== 16'h0) $display("FAIL reset_window: got %h expected 0", window); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_mult_3x5();
        int lat, bc;
        bit both, to;
        exp_t e;
        launch(3, 5);
        start = 1'b0;
        wait_done(1, lat, bc, both, to);
        e = sb.pop_front();
        n_checks++;
        if (to) $display("FAIL m3x5_timeout: got no done after %0d edges", lat); else n_pass++;
        n_checks++;
        if (lat !== LAT_3X5) $display("FAIL m3x5_latency: got %0d expected %0d", lat, LAT_3X5); else n_pass++;
        n_checks++;
        if (bcd !== e.bcd) $display("FAIL m3x5_bcd: got %h expected %h", bcd, e.bcd); else n_pass++;
        n_checks++;
        if (sign !== e.sign) $display("FAIL m3x5_sign: got %b expected %b", sign, e.sign); else n_pass++;
        n_checks++;
        if (bc !== e.lat - 1) $display("FAIL m3x5_busy_cycles: got %0d expected %0d", bc, e.lat - 1); else n_pass++;
        n_checks++;
        if (both) $display("FAIL m3x5_busy_with_done: got busy=1 expected 0"); else n_pass++;
    endtask

    task automatic test_min_neg();
        int lat, bc;
        bit both, to;
        exp_t e;
        launch(-128, -128);
        start = 1'b0;
        wait_done(1, lat, bc, both, to);
        e = sb.pop_front();
        n_checks++;
        if (to || lat !== e.lat) $display("FAIL minneg_latency: got %0d expected %0d", lat, e.lat); else n_pass++;
        n_checks++;
        if (bcd !== e.bcd) $display("FAIL minneg_bcd: got %h expected %h", bcd, e.bcd); else n_pass++;
        n_checks++;
        if (sign !== e.sign) $display("FAIL minneg_sign: got %b expected %b", sign, e.sign); else n_pass++;
        n_checks++;
        if (window !== 16'h6384) $display("FAIL minneg_window0: got %h expected 6384", window); else n_pass++;
        pulse_scroll(1'b1, 1'b0);
        n_checks++;
        if (window !== 16'h1638) $display("FAIL minneg_scroll_l: got %h expected 1638", window); else n_pass++;
        pulse_scroll(1'b1, 1'b0);
        n_checks++;
        if (window !== 16'h1638) $display("FAIL minneg_scroll_l_sat: got %h expected 1638", window); else n_pass++;
        pulse_scroll(1'b0, 1'b1);
        n_checks++;
        if (window !== 16'h6384) $display("FAIL minneg_scroll_r: got %h expected 6384", window); else n_pass++;
    endtask

    task automatic test_scroll_both();
        pulse_scroll(1'b0, 1'b1);
        n_checks++;
        if (window !== 16'h6384) $display("FAIL scroll_r_sat: got %h expected 6384", window); else n_pass++;
        pulse_scroll(1'b1, 1'b0);
        pulse_scroll(1'b1, 1'b1);
        n_checks++;
        if (window !== 16'h1638) $display("FAIL scroll_both: got %h expected 1638", window); else n_pass++;
        pulse_scroll(1'b0, 1'b1);
        n_checks++;
        if (window !== 16'h6384) $display("FAIL scroll_both_then_r: got %h expected 6384", window); else n_pass++;
    endtask

    task automatic test_mixed_signs();
        int lat, bc;
        bit both, to;
        exp_t e;
        launch(12, -11);
        start = 1'b0;
        wait_done(1, lat, bc, both, to);
        e = sb.pop_front();
        n_checks++;
        if (to || lat !== e.lat) $display("FAIL mixed_latency: got %0d expected %0d", lat, e.lat); else n_pass++;
        n_checks++;
        if (bcd !== e.bcd) $display("FAIL mixed_bcd: got %h expected %h", bcd, e.bcd); else n_pass++;
        n_checks++;
        if (sign !== e.sign) $display("FAIL mixed_sign: got %b expected %b", sign, e.sign); else n_pass++;
        n_checks++;
        if (window !== 16'h0132) $display("FAIL mixed_window: got %h expected 0132", window); else n_pass++;
    endtask

    task automatic test_reset_abort();
        int lat, bc, k;
        bit both, to;
        exp_t e;
        launch(3, 5);
        start = 1'b0;
        k = exp_lat(5) - 1 - 2 * WIDTH;
        repeat (k + 5) @(posedge clk);
        #2;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL abort_busy_before: got %b expected 1", busy); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL abort_ctrl: got busy=%b done=%b expected 0 0", busy, done);
        else n_pass++;
        n_checks++;
        if (bcd !== '0 || window !== 16'h0)
            $display("FAIL abort_data: got bcd=%h window=%h expected 0 0", bcd, window);
        else n_pass++;
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        launch(2, 2);
        start = 1'b0;
        wait_done(1, lat, bc, both, to);
        e = sb.pop_front();
        n_checks++;
        if (to || bcd !== e.bcd) $display("FAIL abort_rerun_bcd: got %h expected %h", bcd, e.bcd); else n_pass++;
    endtask

    task automatic test_zero();
        int lat, bc;
        bit both, to;
        exp_t e;
        launch(-7, 0);
        start = 1'b0;
        wait_done(1, lat, bc, both, to);
        e = sb.pop_front();
        n_checks++;
        if (to || lat !== e.lat) $display("FAIL zero_latency: got %0d expected %0d", lat, e.lat); else n_pass++;
        n_checks++;
        if (bcd !== e.bcd) $display("FAIL zero_bcd: got %h expected %h", bcd, e.bcd); else n_pass++;
        n_checks++;
        if (sign !== 1'b0) $display("FAIL zero_sign: got %b expected 0", sign); else n_pass++;
    endtask

    task automatic test_start_held();
        int lat, bc;
        bit both, to;
        exp_t e;
        launch(5, 6);
        wait_done(1, lat, bc, both, to);
        e = sb.pop_front();
        n_checks++;
        if (to || bcd !== e.bcd) $display("FAIL held_bcd: got %h expected %h", bcd, e.bcd); else n_pass++;
        a = WIDTH'(9);
        b = WIDTH'(9);
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0)
            $display("FAIL held_done: got done=%b busy=%b expected 1 0", done, busy);
        else n_pass++;
        n_checks++;
        if (bcd !== e.bcd) $display("FAIL held_no_capture: got %h expected %h", bcd, e.bcd); else n_pass++;
        start = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b0) $display("FAIL held_release: got done=%b expected 0", done); else n_pass++;
    endtask

    task automatic test_start_during_busy();
        int lat, bc;
        bit both, to;
        exp_t e;
        launch(4, 7);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a = WIDTH'(9);
        b = WIDTH'(9);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(3, lat, bc, both, to);
        e = sb.pop_front();
        n_checks++;
        if (to || lat !== e.lat) $display("FAIL busy_start_latency: got %0d expected %0d", lat, e.lat); else n_pass++;
        n_checks++;
        if (bcd !== e.bcd) $display("FAIL busy_start_bcd: got %h expected %h", bcd, e.bcd); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_mult_3x5();
        test_min_neg();
        test_scroll_both();
        test_mixed_signs();
        test_reset_abort();
        test_zero();
        test_start_held();
        test_start_during_busy();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1);
    end

endmodule

// File: doc/mult_bcd_sequencer.md
# mult_bcd_sequencer

Sequencing controller for the signed calculator datapath. It captures two signed operands and multiplies their magnitudes with an internal shift-add engine. It then converts the unsigned product to packed BCD one bit per cycle, and drives a 4-digit scrollable display window over the result. It sits between the operand and button logic and the seven-segment drivers, replacing the purely combinational multiply and BCD path with a multi-cycle, handshaked one.

## Interface
- WIDTH, 8, operand width in bits (two's complement).
- DIGITS, 5, number of BCD result digits. Must satisfy 10^DIGITS > 2^(2*WIDTH-2) and DIGITS >= 4.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset; low forces the reset state immediately.
- start  input  1  level request. Sampled only in IDLE and DONE.
- a, b  input  WIDTH  signed operands.
- scroll_l, scroll_r  input  1  one-cycle pulses that move the display window.
- busy  output  1  high in MULT and CONV.
- done  output  1  high in DONE.
- sign  output  1  result is negative.
- bcd  output  4*DIGITS  packed BCD magnitude; digit 0 is in bits [3:0].
- window  output  16  four consecutive digits of bcd, starting at digit `offset`.

## Operation
- The FSM has four states: IDLE, MULT, CONV and DONE. Reset state is IDLE.
- **IDLE to MULT**, on an edge with start=1:
  - mcand <= |a|, zero-extended to 2*WIDTH bits.
  - mplier <= |b|.
  - prod <= 0 and offset <= 0.
  - sign <= (a<0) XOR (b<0), forced to 0 if a==0 or b==0.
- **MULT**, once per edge:
  - If mplier==0, go to CONV and do not step.
  - Otherwise, add mcand to prod if mplier[0]=1, then shift mcand left 1 and mplier right 1.
  - The early exit applies only with the macro below.
- Magnitude rule: |-2^(WIDTH-1)| = 2^(WIDTH-1), carried unsigned. No overflow is possible.
- **CONV** runs 2*WIDTH edges of double-dabble on a working BCD register, MSB of prod first:
  - First, add 3 to every digit >= 5.
  - Then shift in the next prod bit.
  - A counter 0..2*WIDTH-1 ends the phase.
- **On the final CONV edge:** bcd <= working register, state goes to DONE.
- bcd and sign hold their values until the next start capture. bcd is not cleared at capture.
- **DONE:** remain while start=1. Go to IDLE on the first edge with start=0.
- A start asserted while busy is ignored. Operand changes after capture are ignored.
- **Scroll:** offset ranges 0..DIGITS-4 and is accepted in any state.
  - scroll_l increments offset, saturating at DIGITS-4.
  - scroll_r decrements offset, saturating at 0.
  - Both pulses in the same cycle leave offset unchanged.
  - No wrap-around.
- window = bcd digits [offset+3 : offset], updated combinationally from the offset and bcd registers.

## Timing
- Reset values: busy=0, done=0, sign=0, bcd=0, offset=0, window=0.
- Reset taking effect in any state aborts the operation; nothing is retained.
- MULT edge count k (with macro):
  - k=1 if |b|==0.
  - Otherwise k = (index of the MSB of |b|) + 2.
- done rises 1 + k + 2*WIDTH edges after the edge that sampled start.
- busy is high for exactly k + 2*WIDTH cycles.
- done and busy are never high together.
- The earliest restart is two edges after done rises: one edge with start=0, then a start edge.

## Configuration
- MULT_SEQ_ZERO_SKIP_EN
  - Defined: MULT exits as soon as mplier==0, giving the variable k above.
  - Undefined: MULT always performs exactly WIDTH step edges plus one transition edge, so k = WIDTH+1 for all operands (9 at WIDTH=8).
  - Results are identical either way; only latency differs.

## Test plan
- a=3, b=5, macro defined: done exactly 21 edges after the start edge, bcd=0x00015, sign=0. Same stimulus without the macro: 26 edges, same result.
- a=-128, b=-128: bcd=0x16384, sign=0, window=0x6384. scroll_l: 0x1638. scroll_l again: 0x1638 (saturated). scroll_r: 0x6384.
- a=12, b=-11: bcd=0x00132, sign=1. Then a=-7, b=0: bcd=0, sign=0, done after 18 edges (macro defined).
- Reset asserted at the 5th CONV edge: busy, done, bcd and window go to 0 immediately. After release, a=2, b=2 gives bcd=0x00004.
- Start held high through DONE: done stays high and new operands are not captured. Start pulsed during MULT with different a, b: the result reflects the originally captured operands.
- scroll_l and scroll_r in the same cycle at offset=1: offset remains 1.
